// File: rtl/cnt_pkg.sv
// Shared constants and elaboration helpers for the tick/up-down counter slice.
// Derives the prescaler divide ratio and register width from the clock/tick rates.
package cnt_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
        return int'(clk_hz / tick_hz);
    endfunction

    // A divide ratio of 1 still needs a 1-bit register so the port widths stay legal.
    function automatic int calc_presc_w(input int unsigned clk_hz, input int unsigned tick_hz);
        int div;
        div = calc_div(clk_hz, tick_hz);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider: step is a combinational pulse on the last enabled
// cycle of each DIV-cycle period. clr restarts the period; en=0 preserves the phase.
module tick_prescaler
    import cnt_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int PW  = calc_presc_w(CLK_HZ, TICK_HZ);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign step = en && (presc_q == LAST);

    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = step ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/tick_updown_counter.sv
// Prescaled WIDTH-bit up/down counter with modulus MAX_VAL+1, load, enable and tc pulse.
// Bound behaviour: wraps by default; define CNT_SATURATE_EN to hold at the bound instead.
module tick_updown_counter
    import cnt_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1,
    parameter int          WIDTH   = 4,
    parameter int          MAX_VAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
`ifdef CNT_SATURATE_EN
    localparam logic SATURATE = 1'b1;
`else
    localparam logic SATURATE = 1'b0;
`endif
    // Value taken after a bound hit in each direction.
    localparam logic [WIDTH-1:0] UP_BOUND_NEXT = SATURATE ? MAX_W : '0;
    localparam logic [WIDTH-1:0] DN_BOUND_NEXT = SATURATE ? '0 : MAX_W;

    logic             step;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q,  tick_d;
    logic             tc_q,    tc_d;

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .step (step)
    );

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_W) ? MAX_W : load_val;
        end else if (step) begin
            tick_d = 1'b1;
            if (up_dn == DIR_UP) begin
                if (count_q >= MAX_W) begin
                    tc_d    = 1'b1;
                    count_d = UP_BOUND_NEXT;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = DN_BOUND_NEXT;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign tc    = tc_q;

endmodule

// File: doc/tick_updown_counter.md
# tick_updown_counter

Parametrised successor to the single-purpose 1 Hz divider plus 4-bit up counter. It combines a programmable prescaler that turns the system clock into a one-cycle step tick with a WIDTH-bit up/down counter. The counter has a configurable modulus, synchronous load, enable and terminal-count pulse. It feeds seven-segment drivers and cascaded digit counters; chaining `tc` into the next stage's `en` builds multi-digit counters.

## Interface
Parameters:
- CLK_HZ, 50_000_000, input clock frequency
- TICK_HZ, 1, step rate; DIV = CLK_HZ/TICK_HZ, must be an integer >= 1
- WIDTH, 4, counter width in bits
- MAX_VAL, 2**WIDTH-1, highest count value (modulus MAX_VAL+1); must be >= 1 and <= 2**WIDTH-1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  enable; 0 freezes prescaler and count
- up_dn  in  1  1 = count up, 0 = count down
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value to load
- count  out  WIDTH  current count
- tick  out  1  one-cycle pulse, high in the cycle a new stepped count is visible
- tc  out  1  one-cycle terminal-count pulse, high alongside `tick` when the step crossed a bound

## Operation
- **Priority per edge:** rst > load > en&step > hold.
- **Reset:** count=0, prescaler=0, tick=0, tc=0.
- **load=1:**
  - count <= min(load_val, MAX_VAL); prescaler <= 0; tick <= 0; tc <= 0.
  - `en` is ignored during load.
- **en=1, no load:**
  - Prescaler increments.
  - When prescaler == DIV-1, prescaler <= 0 and a step occurs.
  - DIV=1 steps every enabled cycle.
- **Step, up:**
  - count < MAX_VAL: count+1.
  - count == MAX_VAL: bound hit, tc <= 1; next value set by the bound rule below.
- **Step, down:**
  - count > 0: count-1.
  - count == 0: bound hit, tc <= 1.
- **Step outputs:** tick <= 1 on every step; tick and tc are 0 on all other edges.
- **en=0:** prescaler, count, tick=0 and tc=0 are held or cleared accordingly. The prescaler phase is preserved, not reset.
- **up_dn sampling:** sampled only on the step edge; changing it between steps has no effect until the next step.
- **Width rule:** all arithmetic is in WIDTH bits. The prescaler is $clog2(DIV) bits, minimum 1. No intermediate overflow reaches `count`.

## Timing
- Registered outputs only; no combinational input-to-output path.
- From rst deassertion with en held high, the first step lands on the DIV-th rising edge. `count` and `tick` change on that same edge; the period is exactly DIV cycles.
- After a load edge, the next step occurs DIV enabled cycles later.
- load asserted on a would-be step edge: the load wins and no tick is produced.
- rst mid-period discards the prescaler phase.

## Configuration
- **CNT_SATURATE_EN undefined (default):** wrap on a bound hit. Up goes MAX_VAL -> 0; down goes 0 -> MAX_VAL.
- **CNT_SATURATE_EN defined:**
  - A bound hit holds count at MAX_VAL (up) or 0 (down).
  - tc still pulses on every step attempted at the bound.
  - tick still pulses.

## Structure
- **Package `cnt_pkg`:**
  - function computing DIV and prescaler width from CLK_HZ/TICK_HZ
  - localparam-style direction constants DIR_UP=1, DIR_DN=0
  - typedef for the count word is not shared (WIDTH is per-instance)
- **Sub-module `tick_prescaler`:**
  - params CLK_HZ, TICK_HZ; ports clk, rst, en, clr, step
  - `step` is a combinational pulse on the terminal prescaler cycle
  - the parent registers `tick` and `tc`
- Counter/bound logic lives in the top.

## Test plan
Bench: CLK_HZ=10, TICK_HZ=1 (DIV=10), WIDTH=4, MAX_VAL=9, unless noted.
- rst high 3 cycles, then en=1, up_dn=1 -> count=0 until edge 10, then 1, 2, … every 10 cycles; tick is a single-cycle pulse each time.
- Up wrap from 9 (default build) -> count 9->0 with tc=1 and tick=1 on the same cycle. With CNT_SATURATE_EN: stays 9, tc pulses on each tick.
- up_dn=0 from count=0 -> 0->9 with tc=1 (default); saturate build holds 0 with tc=1. Then 9->8 with tc=0.
- load=1, load_val=12 at prescaler=5 -> count=9 next cycle; next step 10 enabled cycles later. load coinciding with step edge -> tick stays 0.
- en toggled low for 7 cycles mid-period at prescaler=4 -> count frozen, step arrives 7 cycles late; tick/tc never high while en=0.
- DIV=1 (CLK_HZ=TICK_HZ=1), WIDTH=2, MAX_VAL=3 -> count 0,1,2,3,0 on consecutive edges, tick continuously high, tc high on the 3->0 cycle; rst asserted mid-sequence -> count=0, tick=0 on the next edge.
